// File: rtl/nmcu_pkg.sv
// Shared NMCU types and constants: operand width, feeder FSM states and the
// reduction-length ceiling used by the operand sequencer.
package nmcu_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int FEED_K_MAX = 256;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } feeder_state_e;

  // Clamp a requested reduction length to what a job may legally run.
  function automatic int sat_len(input int len, input int lim);
    return (len > lim) ? lim : len;
  endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Beat stream into the feeder: one A column and one B row per valid/ready handshake.
interface systolic_feeder_if
  import nmcu_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = nmcu_pkg::DATA_WIDTH
);

  logic                         in_valid;
  logic                         in_ready;
  logic [ROWS*DATA_WIDTH-1:0]   a_vec;
  logic [COLS*DATA_WIDTH-1:0]   b_vec;

  modport master (output in_valid, output a_vec, output b_vec, input in_ready);
  modport slave  (input in_valid, input a_vec, input b_vec, output in_ready);

endinterface

// File: rtl/systolic_feeder_skew.sv
// Fixed-depth shift register; the feeder uses one per array lane to build the diagonal skew.
module skew_delay_line
  import nmcu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [DEPTH-1:0][WIDTH-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int k = 1; k < DEPTH; k++) begin
        sr_q[k] <= sr_q[k-1];
      end
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Operand sequencer for the output-stationary PE array: skews A/B beats onto the
// array edges, clears accumulators per job and signals when all sums are final.
module systolic_feeder
  import nmcu_pkg::*;
#(
  parameter int DATA_WIDTH = nmcu_pkg::DATA_WIDTH,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int K_MAX      = FEED_K_MAX,
  parameter int K_WIDTH    = $clog2(K_MAX + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_i,
  input  logic [K_WIDTH-1:0]               k_len_i,
  output logic                             busy_o,
  output logic                             done_o,
  systolic_feeder_if.slave                 beat_if,
  output logic                             clear_o,
  output logic                             accum_en_o,
  output logic [ROWS-1:0][DATA_WIDTH-1:0]  operand_a_o,
  output logic [COLS-1:0][DATA_WIDTH-1:0]  operand_b_o
);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_CLEAR = CLEAR;
  localparam logic [2:0] S_FEED  = FEED;
  localparam logic [2:0] S_DRAIN = DRAIN;
  localparam logic [2:0] S_DONE  = DONE;

  localparam int DRAIN_N = ROWS + COLS;
  localparam int DR_W    = $clog2(DRAIN_N + 1);

  logic [2:0]         state_q, state_d;
  logic [K_WIDTH-1:0] k_len_q, k_len_d;
  logic [K_WIDTH-1:0] beat_q, beat_d;
  logic [DR_W-1:0]    drain_q, drain_d;
  logic               accept;

  assign accept = (state_q == S_FEED) && beat_if.in_valid;

  always_comb begin
    state_d = state_q;
    k_len_d = k_len_q;
    beat_d  = beat_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          k_len_d = K_WIDTH'(sat_len(int'(k_len_i), K_MAX));
          beat_d  = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: state_d = (k_len_q == '0) ? S_DONE : S_FEED;
      S_FEED: begin
        if (accept) begin
          beat_d = beat_q + K_WIDTH'(1);
          if (beat_q + K_WIDTH'(1) == k_len_q) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == DR_W'(DRAIN_N - 1)) state_d = S_DONE;
        else                               drain_d = drain_q + DR_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_len_q <= '0;
      beat_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      k_len_q <= k_len_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
    end
  end

  // Outputs are forced low for the whole reset cycle, not just the one after it.
  assign beat_if.in_ready = !rst && (state_q == S_FEED);
  assign clear_o          = !rst && (state_q == S_CLEAR);
  assign accum_en_o       = !rst && ((state_q == S_FEED) || (state_q == S_DRAIN));
  assign busy_o           = !rst && (state_q != S_IDLE);
  assign done_o           = !rst && (state_q == S_DONE);

  // Skew stage: lane n sees beat data n+1 cycles after acceptance; idle cycles inject zero.
  logic signed [DATA_WIDTH-1:0] a_in  [ROWS];
  logic signed [DATA_WIDTH-1:0] a_out [ROWS];
  logic signed [DATA_WIDTH-1:0] b_in  [COLS];
  logic signed [DATA_WIDTH-1:0] b_out [COLS];

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign a_in[r] = accept ? beat_if.a_vec[r*DATA_WIDTH +: DATA_WIDTH] : '0;
    skew_delay_line #(.WIDTH(DATA_WIDTH), .DEPTH(r + 1)) u_skew (
      .clk(clk), .rst(rst), .d_i(a_in[r]), .q_o(a_out[r])
    );
    assign operand_a_o[r] = rst ? '0 : a_out[r];
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    assign b_in[c] = accept ? beat_if.b_vec[c*DATA_WIDTH +: DATA_WIDTH] : '0;
    skew_delay_line #(.WIDTH(DATA_WIDTH), .DEPTH(c + 1)) u_skew (
      .clk(clk), .rst(rst), .d_i(b_in[c]), .q_o(b_out[c])
    );
    assign operand_b_o[c] = rst ? '0 : b_out[c];
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized scoreboard bench for systolic_feeder with an idealised PE-array model.
module tb_systolic_feeder;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int DW    = 8;
  localparam int K_MAX = 256;
  localparam int KW    = $clog2(K_MAX + 1);
  localparam int MAXC  = 4096;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic [KW-1:0]            k_len;
  logic                     busy, done, clear, accen;
  logic [ROWS-1:0][DW-1:0]  opa;
  logic [COLS-1:0][DW-1:0]  opb;

  systolic_feeder_if #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW)) bif ();

  systolic_feeder #(.DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX)) dut (
    .clk(clk), .rst(rst), .start_i(start), .k_len_i(k_len), .busy_o(busy), .done_o(done),
    .beat_if(bif), .clear_o(clear), .accum_en_o(accen),
    .operand_a_o(opa), .operand_b_o(opb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  bit exp_clear [MAXC];
  bit exp_acc   [MAXC];
  bit exp_rdy   [MAXC];
  bit exp_busy  [MAXC];
  bit exp_done  [MAXC];
  bit rst_h     [MAXC];
  bit beat_v    [MAXC];
  int beat_a    [MAXC][ROWS];
  int beat_b    [MAXC][COLS];
  int ha        [MAXC][ROWS];
  int hb        [MAXC][COLS];
  int acc       [ROWS][COLS];
  int done_q[$];
  int res_q[$];

  logic [ROWS-1:0][DW-1:0] ea;
  logic [COLS-1:0][DW-1:0] eb;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit clean(input int c);
    for (int t = c; t <= cyc; t++) if (rst_h[t]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int gen_a(input int dsel, input int k, input int i);
    case (dsel)
      0:       return (i == k) ? 1 : 0;
      1:       return -1;
      default: return int'($urandom_range(0, 255)) - 128;
    endcase
  endfunction

  function automatic int gen_b(input int dsel, input int k, input int j);
    case (dsel)
      0:       return 4 * k + j + 1;
      1:       return 2;
      default: return int'($urandom_range(0, 255)) - 128;
    endcase
  endfunction

  // Monitor: per-cycle control/operand checks, PE-array model, done scoreboard.
  task automatic check_cycle();
    int c, ta, tb, d, r;
    chk("clear_o", clear, exp_clear[cyc]);
    chk("accum_en_o", accen, exp_acc[cyc]);
    chk("in_ready_o", bif.in_ready, exp_rdy[cyc]);
    chk("busy_o", busy, exp_busy[cyc]);
    chk("done_o", done, exp_done[cyc]);
    ea = '0;
    eb = '0;
    for (int i = 0; i < ROWS; i++) begin
      c = cyc - 1 - i;
      if (c >= 1 && beat_v[c] && clean(c)) ea[i] = DW'(beat_a[c][i]);
    end
    for (int j = 0; j < COLS; j++) begin
      c = cyc - 1 - j;
      if (c >= 1 && beat_v[c] && clean(c)) eb[j] = DW'(beat_b[c][j]);
    end
    chk("operand_a_o", opa, ea);
    chk("operand_b_o", opb, eb);
    for (int i = 0; i < ROWS; i++) ha[cyc][i] = int'($signed(opa[i]));
    for (int j = 0; j < COLS; j++) hb[cyc][j] = int'($signed(opb[j]));
    if (clear === 1'b1)
      for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS; j++) acc[i][j] = 0;
    if (accen === 1'b1)
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) begin
          ta = cyc - j;
          tb = cyc - i;
          if (ta >= 1 && tb >= 1) acc[i][j] += ha[ta][i] * hb[tb][j];
        end
    if (done === 1'b1) begin
      if (done_q.size() == 0) begin
        chk("done_spurious", 1, 0);
      end else begin
        d = done_q.pop_front();
        chk("done_cycle", cyc, d);
        for (int i = 0; i < ROWS; i++)
          for (int j = 0; j < COLS; j++) begin
            r = res_q.pop_front();
            chk("result", acc[i][j], r);
          end
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cyc >= 1 && cyc < MAXC) check_cycle();
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    rst          = 1'b0;
    start        = 1'b0;
    bif.in_valid = 1'b0;
    bif.a_vec    = $urandom;
    bif.b_vec    = $urandom;
  endtask

  task automatic job(input int kreq, input int vmode, input int dsel, input int rst_at);
    int k, nb, fi, av, bv;
    int exp_res[ROWS][COLS];
    bit v;
    k = (kreq > K_MAX) ? K_MAX : kreq;
    next_cycle();
    start = 1'b1;
    k_len = KW'(kreq);
    next_cycle();
    exp_clear[cyc] = 1'b1;
    exp_busy[cyc]  = 1'b1;
    if (k == 0) begin
      done_q.push_back(cyc + 1);
      for (int n = 0; n < ROWS * COLS; n++) res_q.push_back(0);
      next_cycle();
      exp_done[cyc] = 1'b1;
      exp_busy[cyc] = 1'b1;
      return;
    end
    for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS; j++) exp_res[i][j] = 0;
    nb = 0;
    fi = 0;
    while (nb < k) begin
      next_cycle();
      case (vmode)
        0:       v = 1'b1;
        1:       v = (fi % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      fi++;
      if (vmode == 2) start = 1'($urandom_range(0, 1));
      if (rst_at == nb + 1) begin
        rst          = 1'b1;
        bif.in_valid = 1'b1;
        rst_h[cyc]   = 1'b1;
        next_cycle();
        return;
      end
      exp_rdy[cyc]  = 1'b1;
      exp_acc[cyc]  = 1'b1;
      exp_busy[cyc] = 1'b1;
      bif.in_valid  = v;
      if (v) begin
        beat_v[cyc] = 1'b1;
        for (int i = 0; i < ROWS; i++) begin
          av = gen_a(dsel, nb, i);
          beat_a[cyc][i] = av;
          bif.a_vec[i*DW +: DW] = DW'(av);
        end
        for (int j = 0; j < COLS; j++) begin
          bv = gen_b(dsel, nb, j);
          beat_b[cyc][j] = bv;
          bif.b_vec[j*DW +: DW] = DW'(bv);
        end
        for (int i = 0; i < ROWS; i++)
          for (int j = 0; j < COLS; j++) exp_res[i][j] += beat_a[cyc][i] * beat_b[cyc][j];
        nb++;
      end
    end
    done_q.push_back(cyc + ROWS + COLS + 1);
    for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS; j++) res_q.push_back(exp_res[i][j]);
    for (int n = 0; n < ROWS + COLS; n++) begin
      next_cycle();
      if (vmode == 2) start = 1'($urandom_range(0, 1));
      exp_acc[cyc]  = 1'b1;
      exp_busy[cyc] = 1'b1;
    end
    next_cycle();
    exp_done[cyc] = 1'b1;
    exp_busy[cyc] = 1'b1;
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    k_len        = '0;
    bif.in_valid = 1'b0;
    bif.a_vec    = '0;
    bif.b_vec    = '0;
    for (int n = 0; n < 3; n++) begin
      next_cycle();
      rst        = 1'b1;
      start      = 1'b1;
      rst_h[cyc] = 1'b1;
    end
    next_cycle();
    job(4, 0, 0, 0);
    job(4, 1, 0, 0);
    job(3, 0, 1, 0);
    job(3, 2, 2, 0);
    job(0, 0, 0, 0);
    next_cycle();
    job(4, 0, 2, 2);
    job(4, 0, 0, 0);
    for (int n = 0; n < 6; n++) job(int'($urandom_range(1, 12)), 2, 2, 0);
    job(300, 2, 2, 0);
    job(1, 0, 2, 0);
    for (int n = 0; n < 3; n++) next_cycle();
    @(negedge clk);
    #1;
    chk("done_queue_empty", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
